stepper_axis_driver: RTL and testbench

- Consumer end of the 2-bit motor command bus emitted by the axis motion controller (s_out_theta / s_out_phi).
- Translates each command into a full-step coil sequence for one stepper axis.
- Tracks the axis position in steps and returns it as the "actual position" that the motion controller compares against.
- One instance is used per axis (theta, phi).

---
 rtl/stepper_axis_driver.sv | 146 ++++++++++++++
 tb/tb_stepper_axis_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stepper_axis_driver.sv
// Full-step stepper driver for one axis: turns the 2-bit motor command into a
// coil sequence and tracks the axis position, which it reports back as the actual position.
module stepper_axis_driver #(
    parameter int STEP_DIV   = 50000,
    parameter int POS_MAX    = 360,
    parameter int POS_INIT   = 0,
    parameter int HOLD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cmd,
    output logic [3:0]  coils,
    output logic [15:0] pos,
    output logic        step_pulse,
    output logic        dir,
    output logic        moving,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);
    localparam logic [15:0] POS_LAST = 16'(POS_MAX - 1);
    localparam logic [7:0]  HOLD_LIM = 8'(HOLD_TICKS);

    state_t      state, state_n;
    logic [15:0] presc, presc_n;
    logic [1:0]  phase, phase_n;
    logic [15:0] pos_n;
    logic        run_dir, run_dir_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [3:0]  coils_n;
    logic        dir_n;
    logic        tick, do_step, step_dir;

    // cmd[0] = run request, cmd[1] = direction (1 = anti-clockwise); 10 is a stop
    wire cmd_run = cmd[0];
    wire cmd_dir = cmd[1];

    assign tick      = (state != S_IDLE) && (presc == DIV_LAST);
    assign moving    = (state == S_STEP) || (state == S_SETTLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            phase      <= '0;
            pos        <= 16'(POS_INIT);
            run_dir    <= 1'b0;
            hold_cnt   <= '0;
            coils      <= '0;
            step_pulse <= 1'b0;
            dir        <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            phase      <= phase_n;
            pos        <= pos_n;
            run_dir    <= run_dir_n;
            hold_cnt   <= hold_n;
            coils      <= coils_n;
            step_pulse <= do_step;
            dir        <= dir_n;
        end
    end

    always_comb begin
        state_n   = state;
        presc_n   = (state == S_IDLE || tick) ? 16'd0 : presc + 16'd1;
        phase_n   = phase;
        pos_n     = pos;
        run_dir_n = run_dir;
        hold_n    = hold_cnt;
        dir_n     = dir;
        do_step   = 1'b0;
        step_dir  = run_dir;
        coils_n   = '0;

        case (state)
            S_IDLE: begin
                if (cmd_run) begin
                    state_n   = S_STEP;
                    run_dir_n = cmd_dir;
                    hold_n    = 8'd0;
                end
            end
            S_STEP: begin
                if (tick) begin
                    if (!cmd_run) begin
                        state_n = (HOLD_LIM <= 8'd1) ? S_IDLE : S_HOLD;
                        hold_n  = 8'd1;
                    end else if (cmd_dir == run_dir) begin
                        do_step = 1'b1;
                    end else begin
                        state_n   = S_SETTLE;
                        run_dir_n = cmd_dir;
                    end
                end
            end
            default: begin
                // SETTLE and HOLD: any run command steps at once in its own direction
                if (tick) begin
                    if (cmd_run) begin
                        do_step   = 1'b1;
                        step_dir  = cmd_dir;
                        run_dir_n = cmd_dir;
                        state_n   = S_STEP;
                    end else if (state == S_SETTLE) begin
                        state_n = (HOLD_LIM <= 8'd1) ? S_IDLE : S_HOLD;
                        hold_n  = 8'd1;
                    end else begin
                        hold_n = hold_cnt + 8'd1;
                        if (hold_n >= HOLD_LIM) state_n = S_IDLE;
                    end
                end
            end
        endcase

        if (do_step) begin
            dir_n = step_dir;
            if (step_dir) begin
                phase_n = phase + 2'd1;
                pos_n   = (pos >= POS_LAST) ? 16'd0 : pos + 16'd1;
            end else begin
                phase_n = phase - 2'd1;
                pos_n   = (pos == 16'd0) ? POS_LAST : pos - 16'd1;
            end
        end

        if (state_n != S_IDLE) begin
            case (phase_n)
                2'd0:    coils_n = 4'b0011;
                2'd1:    coils_n = 4'b0110;
                2'd2:    coils_n = 4'b1100;
                default: coils_n = 4'b1001;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Directed bench for stepper_axis_driver with a short step period and an 8-position axis.
module tb_stepper_axis_driver;

    localparam int STEP_DIV = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd = 2'b00;
    logic [3:0]  coils;
    logic [15:0] pos;
    logic        step_pulse;
    logic        dir;
    logic        moving;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    stepper_axis_driver #(
        .STEP_DIV  (STEP_DIV),
        .POS_MAX   (8),
        .POS_INIT  (0),
        .HOLD_TICKS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .coils     (coils),
        .pos       (pos),
        .step_pulse(step_pulse),
        .dir       (dir),
        .moving    (moving),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // full observable snapshot
    task automatic expect_all(input string tag, input logic [3:0] e_coils, input logic [15:0] e_pos,
                              input logic e_pulse, input logic e_dir, input logic e_moving,
                              input logic [1:0] e_state);
        check({tag, ".coils"}, 16'(coils), 16'(e_coils));
        check({tag, ".pos"}, pos, e_pos);
        check({tag, ".pulse"}, 16'(step_pulse), 16'(e_pulse));
        check({tag, ".dir"}, 16'(dir), 16'(e_dir));
        check({tag, ".moving"}, 16'(moving), 16'(e_moving));
        check({tag, ".state"}, 16'(state_dbg), 16'(e_state));
    endtask

    initial begin
        // reset
        #12;
        expect_all("reset", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        cyc(1);
        rst = 1'b0;
        cyc(2);
        expect_all("idle", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0, ST_IDLE);

        // anti-clockwise run
        cmd = 2'b11;
        cyc(1);
        expect_all("start", 4'b0011, 16'd0, 1'b0, 1'b0, 1'b1, ST_STEP);
        cyc(3);
        check("no_step_before_tick", 16'(step_pulse), 16'd0);
        cyc(1);
        expect_all("acw1", 4'b0110, 16'd1, 1'b1, 1'b1, 1'b1, ST_STEP);
        cyc(1);
        check("pulse_one_cycle", 16'(step_pulse), 16'd0);
        cyc(3);
        expect_all("acw2", 4'b1100, 16'd2, 1'b1, 1'b1, 1'b1, ST_STEP);
        cyc(4);
        expect_all("acw3", 4'b1001, 16'd3, 1'b1, 1'b1, 1'b1, ST_STEP);

        // reversal: one settle period, then clockwise steps
        cmd = 2'b01;
        cyc(4);
        expect_all("settle", 4'b1001, 16'd3, 1'b0, 1'b1, 1'b1, ST_SETTLE);
        cyc(4);
        expect_all("cw2", 4'b1100, 16'd2, 1'b1, 1'b0, 1'b1, ST_STEP);
        cyc(4);
        expect_all("cw1", 4'b0110, 16'd1, 1'b1, 1'b0, 1'b1, ST_STEP);
        cyc(4);
        expect_all("cw0", 4'b0011, 16'd0, 1'b1, 1'b0, 1'b1, ST_STEP);
        cyc(4);
        expect_all("wrap_cw", 4'b1001, 16'd7, 1'b1, 1'b0, 1'b1, ST_STEP);

        // reverse at pos 7 and wrap anti-clockwise
        cmd = 2'b11;
        cyc(4);
        expect_all("settle2", 4'b1001, 16'd7, 1'b0, 1'b0, 1'b1, ST_SETTLE);
        cyc(4);
        expect_all("wrap_acw", 4'b0011, 16'd0, 1'b1, 1'b1, 1'b1, ST_STEP);

        // stop: hold two ticks, then release
        cmd = 2'b00;
        cyc(4);
        expect_all("hold1", 4'b0011, 16'd0, 1'b0, 1'b1, 1'b0, ST_HOLD);
        cyc(3);
        check("hold_mid.coils", 16'(coils), 16'(4'b0011));
        cyc(1);
        expect_all("release", 4'b0000, 16'd0, 1'b0, 1'b1, 1'b0, ST_IDLE);

        // restart, then resume from hold without settle
        cmd = 2'b11;
        cyc(1);
        expect_all("restart", 4'b0011, 16'd0, 1'b0, 1'b1, 1'b1, ST_STEP);
        cyc(4);
        expect_all("r_acw1", 4'b0110, 16'd1, 1'b1, 1'b1, 1'b1, ST_STEP);
        cmd = 2'b00;
        cyc(4);
        expect_all("hold_r", 4'b0110, 16'd1, 1'b0, 1'b1, 1'b0, ST_HOLD);
        cmd = 2'b11;
        cyc(4);
        expect_all("resume", 4'b1100, 16'd2, 1'b1, 1'b1, 1'b1, ST_STEP);

        // invalid command 10 acts as stop
        cmd = 2'b10;
        cyc(4);
        expect_all("cmd10", 4'b1100, 16'd2, 1'b0, 1'b1, 1'b0, ST_HOLD);
        cmd = 2'b11;
        cyc(4);
        expect_all("acw3b", 4'b1001, 16'd3, 1'b1, 1'b1, 1'b1, ST_STEP);
        cyc(4);
        expect_all("acw4", 4'b0011, 16'd4, 1'b1, 1'b1, 1'b1, ST_STEP);
        cyc(4);
        expect_all("acw5", 4'b0110, 16'd5, 1'b1, 1'b1, 1'b1, ST_STEP);

        // asynchronous reset mid-run, no clock edge in between
        rst = 1'b1;
        #1;
        expect_all("async_rst", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0, ST_IDLE);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        expect_all("post_rst", 4'b0011, 16'd0, 1'b0, 1'b0, 1'b1, ST_STEP);
        cyc(STEP_DIV);
        expect_all("post_rst_step", 4'b0110, 16'd1, 1'b1, 1'b1, 1'b1, ST_STEP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
